// File: rtl/koa_mult_arbiter_if.sv
// Requester/multiplier-side bus of the shared Karatsuba multiplier arbiter.
// The slave modport is the arbiter; the master modport is its environment (requesters and multiplier).
interface koa_mult_arbiter_if #(
  parameter int unsigned SW = 24
);
  logic [1:0]      req_i;
  logic [SW-1:0]   data0_a_i;
  logic [SW-1:0]   data0_b_i;
  logic [SW-1:0]   data1_a_i;
  logic [SW-1:0]   data1_b_i;
  logic [1:0]      grant_o;
  logic [1:0]      done_o;
  logic [2*SW-1:0] result_o;
  logic            busy_o;
  logic [SW-1:0]   mul_a_o;
  logic [SW-1:0]   mul_b_o;
  logic            mul_load_o;
  logic [2*SW-1:0] mul_result_i;

  modport slave (
    input  req_i, data0_a_i, data0_b_i, data1_a_i, data1_b_i, mul_result_i,
    output grant_o, done_o, result_o, busy_o, mul_a_o, mul_b_o, mul_load_o
  );

  modport master (
    output req_i, data0_a_i, data0_b_i, data1_a_i, data1_b_i, mul_result_i,
    input  grant_o, done_o, result_o, busy_o, mul_a_o, mul_b_o, mul_load_o
  );
endinterface

// File: rtl/koa_mult_arbiter.sv
// Round-robin arbiter sharing one registered KOA significand multiplier between two requesters.
// Optional feature: define KOA_ARB_ZERO_SKIP_EN to bypass the multiplier when an operand is zero.
module koa_mult_arbiter #(
  parameter int unsigned SW     = 24,
  parameter int unsigned SETTLE = 2
) (
  input  logic               clk,
  input  logic               rst,
  koa_mult_arbiter_if.slave  bus
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            owner;
  logic            last_grant;
  logic            win;
  logic [SW-1:0]   sel_a;
  logic [SW-1:0]   sel_b;
`ifdef KOA_ARB_ZERO_SKIP_EN
  logic            zero;
`endif

  // Winner selection: on a tie the requester that was not granted last wins.
  always_comb begin
    win = 1'b0;
    if (bus.req_i == 2'b11) begin
      win = ~last_grant;
    end else begin
      win = bus.req_i[1];
    end
    sel_a = win ? bus.data1_a_i : bus.data0_a_i;
    sel_b = win ? bus.data1_b_i : bus.data0_b_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      owner          <= 1'b0;
      last_grant     <= 1'b1;
      bus.grant_o    <= '0;
      bus.done_o     <= '0;
      bus.result_o   <= '0;
      bus.busy_o     <= 1'b0;
      bus.mul_a_o    <= '0;
      bus.mul_b_o    <= '0;
      bus.mul_load_o <= 1'b0;
`ifdef KOA_ARB_ZERO_SKIP_EN
      zero           <= 1'b0;
`endif
    end else begin
      bus.grant_o    <= '0;
      bus.done_o     <= '0;
      bus.mul_load_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|bus.req_i) begin
            bus.mul_a_o <= sel_a;
            bus.mul_b_o <= sel_b;
            owner       <= win;
            last_grant  <= win;
            bus.grant_o <= {win, ~win};
            cnt         <= CW'(SETTLE - 1);
            bus.busy_o  <= 1'b1;
            state       <= S_SETTLE;
`ifdef KOA_ARB_ZERO_SKIP_EN
            zero        <= (sel_a == '0) || (sel_b == '0);
`endif
          end
        end
        S_SETTLE: begin
`ifdef KOA_ARB_ZERO_SKIP_EN
          // Zero operand: the grant cycle is the only wait, the multiplier is never loaded.
          if (zero) begin
            state <= S_DONE;
          end else
`endif
          if (cnt == '0) begin
            bus.mul_load_o <= 1'b1;
            state          <= S_LOAD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_LOAD: begin
          state <= S_DONE;
        end
        S_DONE: begin
`ifdef KOA_ARB_ZERO_SKIP_EN
          bus.result_o <= zero ? '0 : bus.mul_result_i;
`else
          bus.result_o <= bus.mul_result_i;
`endif
          bus.done_o   <= {owner, ~owner};
          bus.busy_o   <= 1'b0;
          state        <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_koa_mult_arbiter.sv
// Directed self-checking bench for koa_mult_arbiter with a behavioural registered multiplier.
module tb_koa_mult_arbiter;

  localparam int unsigned SW = 24;
  localparam int unsigned S  = 2;
`ifdef KOA_ARB_ZERO_SKIP_EN
  localparam int ZD = 3;
`else
  localparam int ZD = 5;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [2*SW-1:0] mul_reg;

  koa_mult_arbiter_if #(.SW(SW)) bus ();

  koa_mult_arbiter #(.SW(SW), .SETTLE(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Multiplier wrapper model: result register loads on the strobe.
  always @(posedge clk) begin
    if (rst) mul_reg <= '0;
    else if (bus.mul_load_o) mul_reg <= (2*SW)'(bus.mul_a_o) * (2*SW)'(bus.mul_b_o);
  end
  assign bus.mul_result_i = mul_reg;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_i = 2'b11;
    bus.data0_a_i = 24'd1; bus.data0_b_i = 24'd1;
    bus.data1_a_i = 24'd2; bus.data1_b_i = 24'd2;
    step(); step();
    checks++;
    if ({bus.grant_o, bus.done_o, bus.busy_o, bus.mul_load_o} !== 6'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b want=000000", {bus.grant_o, bus.done_o, bus.busy_o, bus.mul_load_o});
    end
    checks++;
    if ({bus.result_o, bus.mul_a_o, bus.mul_b_o} !== 96'h0) begin
      failures++; $display("FAIL reset_data got=%h want=0", {bus.result_o, bus.mul_a_o, bus.mul_b_o});
    end
    rst = 1'b0;
    step();
    checks++;
    if (bus.grant_o !== 2'b01) begin
      failures++; $display("FAIL reset_first_grant got=%b want=01", bus.grant_o);
    end
    bus.req_i = 2'b00;
    begin
      int n = 0;
      while (bus.done_o === 2'b00 && n < 10) begin step(); n++; end
      checks++;
      if (bus.done_o !== 2'b01 || bus.result_o !== 48'd1) begin
        failures++; $display("FAIL reset_first_done got=%b/%h want=01/1", bus.done_o, bus.result_o);
      end
    end
  endtask

  task automatic test_single_op();
    bus.data0_a_i = 24'h800000; bus.data0_b_i = 24'h000003;
    bus.req_i = 2'b01;
    for (int c = 1; c <= 6; c++) begin
      step();
      checks++;
      if (bus.grant_o !== ((c == 1) ? 2'b01 : 2'b00) || bus.mul_load_o !== (c == S + 1) ||
          bus.done_o !== ((c == S + 3) ? 2'b01 : 2'b00) || bus.busy_o !== (c >= 1 && c <= S + 2)) begin
        failures++;
        $display("FAIL single_cycle%0d got grant=%b load=%b done=%b busy=%b", c, bus.grant_o, bus.mul_load_o, bus.done_o, bus.busy_o);
      end
      if (c == 1) begin
        bus.req_i = 2'b00;
        bus.data0_a_i = 24'h123456; bus.data0_b_i = 24'h654321;
      end
      if (c == S + 3) begin
        checks++;
        if (bus.result_o !== 48'h000001_800000) begin
          failures++; $display("FAIL single_result got=%h want=000001800000", bus.result_o);
        end
        checks++;
        if (bus.mul_a_o !== 24'h800000 || bus.mul_b_o !== 24'h000003) begin
          failures++; $display("FAIL single_operand_hold got=%h/%h want=800000/000003", bus.mul_a_o, bus.mul_b_o);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]      exp_g;
    logic [2*SW-1:0] exp_r;
    rst = 1'b1; step(); rst = 1'b0;
    bus.data0_a_i = 24'd2;     bus.data0_b_i = 24'd3;
    bus.data1_a_i = 24'h000100; bus.data1_b_i = 24'h000010;
    bus.req_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_r = (k % 2 == 0) ? 48'd6 : 48'h1000;
      for (int c = 1; c <= S + 3; c++) begin
        step();
        if (c == 1) begin
          checks++;
          if (bus.grant_o !== exp_g) begin
            failures++; $display("FAIL rr_grant%0d got=%b want=%b", k, bus.grant_o, exp_g);
          end
          bus.req_i = bus.req_i & ~exp_g;
        end
        if (c == S + 3) begin
          checks++;
          if (bus.done_o !== exp_g || bus.result_o !== exp_r) begin
            failures++; $display("FAIL rr_done%0d got=%b/%h want=%b/%h", k, bus.done_o, bus.result_o, exp_g, exp_r);
          end
          bus.req_i = (k < 3) ? 2'b11 : 2'b00;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bus.data0_a_i = 24'd5; bus.data0_b_i = 24'd7;
    bus.req_i = 2'b01;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) bus.req_i = 2'b00;
      if (c == 5) begin
        checks++;
        if (bus.done_o !== 2'b01 || bus.result_o !== 48'h23) begin
          failures++; $display("FAIL b2b_first got=%b/%h want=01/23", bus.done_o, bus.result_o);
        end
        bus.data1_a_i = 24'h10; bus.data1_b_i = 24'h10;
        bus.req_i = 2'b10;
      end
      if (c == 6) begin
        checks++;
        if (bus.grant_o !== 2'b10) begin
          failures++; $display("FAIL b2b_grant got=%b want=10", bus.grant_o);
        end
        bus.req_i = 2'b00;
      end
      if (c == 9) begin
        checks++;
        if (bus.done_o !== 2'b00 || bus.result_o !== 48'h23) begin
          failures++; $display("FAIL b2b_hold got=%b/%h want=00/23", bus.done_o, bus.result_o);
        end
      end
      if (c == 10) begin
        checks++;
        if (bus.done_o !== 2'b10 || bus.result_o !== 48'h100) begin
          failures++; $display("FAIL b2b_second got=%b/%h want=10/100", bus.done_o, bus.result_o);
        end
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int n;
    bus.data0_a_i = 24'd3; bus.data0_b_i = 24'd3;
    bus.req_i = 2'b01;
    step();
    bus.req_i = 2'b00;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({bus.done_o, bus.busy_o, bus.grant_o, bus.mul_load_o} !== 6'b0 || bus.result_o !== 48'h0) begin
      failures++; $display("FAIL midrst_clear got done=%b busy=%b result=%h want 00/0/0", bus.done_o, bus.busy_o, bus.result_o);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (bus.done_o !== 2'b00 || bus.busy_o !== 1'b0) begin
        failures++; $display("FAIL midrst_quiet%0d got done=%b busy=%b want 00/0", c, bus.done_o, bus.busy_o);
      end
    end
    bus.data1_a_i = 24'd4; bus.data1_b_i = 24'd4;
    bus.req_i = 2'b10;
    step();
    bus.req_i = 2'b00;
    n = 1;
    while (bus.done_o === 2'b00 && n < 12) begin step(); n++; end
    checks++;
    if (bus.done_o !== 2'b10 || bus.result_o !== 48'h10 || n != S + 3) begin
      failures++; $display("FAIL midrst_recover got=%b/%h cycle=%0d want=10/10 cycle=%0d", bus.done_o, bus.result_o, n, S + 3);
    end
  endtask

  task automatic test_zero();
    logic load_seen = 1'b0;
    bus.data0_a_i = 24'h0; bus.data0_b_i = 24'hABCDEF;
    bus.req_i = 2'b01;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) bus.req_i = 2'b00;
      if (bus.mul_load_o === 1'b1 && ZD == 3) load_seen = 1'b1;
      checks++;
      if (bus.done_o !== ((c == ZD) ? 2'b01 : 2'b00)) begin
        failures++; $display("FAIL zero_done_cycle%0d got=%b", c, bus.done_o);
      end
      if (c == ZD) begin
        checks++;
        if (bus.result_o !== 48'h0) begin
          failures++; $display("FAIL zero_result got=%h want=0", bus.result_o);
        end
      end
    end
    checks++;
    if (load_seen !== 1'b0) begin
      failures++; $display("FAIL zero_no_load got=%b want=0", load_seen);
    end
  endtask

  initial begin
    bus.req_i = 2'b00;
    bus.data0_a_i = '0; bus.data0_b_i = '0;
    bus.data1_a_i = '0; bus.data1_b_i = '0;
    test_reset();
    test_single_op();
    test_round_robin();
    test_back_to_back();
    test_reset_mid_op();
    test_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
